dm_sized: RTL and testbench

Parametrised data memory for the single-cycle/multi-cycle MIPS datapath, replacing the word-only DM.
- Supports byte, half and word stores and loads, with sign/zero extension on loads.
- Read data is registered (1-cycle latency) behind a req/ready handshake.
- Reset clears memory one word per cycle under a small state machine; the block reports Busy while clearing.
- Sits between the ALU address path and the writeback mux.

---
 rtl/dm_pkg.sv | 37 +++
 rtl/dm_lane_unit.sv | 61 ++++++
 rtl/dm_sized.sv | 181 ++++++++++++++++++
 tb/tb_dm_sized.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the sized data memory.
//   - Access size codes carried on the Size port.
//   - State encoding for the clear/idle state machine.
//   - lane_be(): byte-enable generation from the low address bits and the
//     access size. It returns 4'b0000 for any misaligned or illegal access,
//     so "no lanes enabled" doubles as the misalign flag.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dm_state_e;

  // Little-endian lane selection: Addr[1:0]=0 maps to bits [7:0].
  function automatic logic [3:0] lane_be(input logic [1:0] addr_lo,
                                         input logic [1:0] size);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: begin
        if (addr_lo[0])      be = 4'b0000;
        else if (addr_lo[1]) be = 4'b1100;
        else                 be = 4'b0011;
      end
      SZ_WORD: be = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: purely combinational lane logic for the sized data memory.
// Ports:
//   addr_lo     in   2  byte offset within the word (Addr[1:0])
//   size        in   2  access size (SZ_BYTE / SZ_HALF / SZ_WORD / illegal)
//   is_unsigned in   1  1 = zero-extend loads, 0 = sign-extend
//   wdata       in  32  right-aligned store data
//   raw_word    in  32  current memory word at the addressed index
//   byte_en     out  4  lanes written by a store
//   wdata_sh    out 32  store data replicated onto every candidate lane
//   rdata_ext   out 32  lane-selected, extended load value
//   misalign    out  1  access is misaligned or uses the illegal size
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_en  = lane_be(addr_lo, size);
    misalign = (byte_en == 4'b0000);

    // Replicating the store data means every lane already holds the right
    // bits; byte_en alone decides which of them land in memory.
    case (size)
      SZ_BYTE: wdata_sh = {4{wdata[7:0]}};
      SZ_HALF: wdata_sh = {2{wdata[15:0]}};
      default: wdata_sh = wdata;
    endcase

    case (addr_lo)
      2'b00:   byte_sel = raw_word[7:0];
      2'b01:   byte_sel = raw_word[15:8];
      2'b10:   byte_sel = raw_word[23:16];
      default: byte_sel = raw_word[31:24];
    endcase
    half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    rdata_ext = 32'h0;
    if (!misalign) begin
      case (size)
        SZ_BYTE: rdata_ext = is_unsigned ? {24'h0, byte_sel}
                                         : {{24{byte_sel[7]}}, byte_sel};
        SZ_HALF: rdata_ext = is_unsigned ? {16'h0, half_sel}
                                         : {{16{half_sel[15]}}, half_sel};
        default: rdata_ext = raw_word;
      endcase
    end
  end

endmodule

// File: rtl/dm_sized.sv
// dm_sized: byte/half/word data memory for the MIPS datapath.
// Loads return one cycle after acceptance; after reset the memory is
// optionally zero-filled one word per cycle while Busy is high.
// Ports:
//   Clk       in   1  clock
//   reset     in   1  synchronous active-high reset
//   PC        in  32  PC of the issuing instruction (write trace only)
//   Addr      in  32  byte address; only Addr[ADDR_WIDTH+1:0] selects data
//   WData     in  32  right-aligned store data
//   Req       in   1  access request
//   WE        in   1  1 = store, 0 = load
//   Size      in   2  00 byte, 01 half, 10 word, 11 illegal
//   Unsigned  in   1  1 = zero-extend load, 0 = sign-extend
//   Ready     out  1  request is accepted this cycle when Req is high
//   Busy      out  1  zero-fill in progress
//   RValid    out  1  load result valid (single-cycle pulse)
//   RData     out 32  extended load result, 0 whenever RValid is low
//   AddrErr   out  1  previous accepted request was misaligned/illegal
module dm_sized
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit TRACE          = 1'b1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        Req,
  input  logic        WE,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic        Ready,
  output logic        Busy,
  output logic        RValid,
  output logic [31:0] RData,
  output logic        AddrErr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  dm_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  addr_err_q, addr_err_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           raw_word;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_sh;
  logic [31:0]           rdata_ext;
  logic                  misalign;
  logic [31:0]           merged;
  logic                  accept;
  logic                  store_commit;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [31:0]           mem_wdata;

  // Upper address bits alias onto the same words; PC only feeds the trace.
  logic unused_inputs;
  assign unused_inputs = ^{PC, Addr[31:ADDR_WIDTH+2]};

  assign word_idx = Addr[ADDR_WIDTH+1:2];
  assign raw_word = mem[word_idx];

  dm_lane_unit u_lane (
    .addr_lo     (Addr[1:0]),
    .size        (Size),
    .is_unsigned (Unsigned),
    .wdata       (WData),
    .raw_word    (raw_word),
    .byte_en     (byte_en),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // Ready is a flop, so acceptance never depends on the request itself.
  // Reset drops any request presented in the same cycle.
  assign accept       = Req && ready_q && !reset;
  assign store_commit = accept && WE && !misalign;

  always_comb begin
    merged = raw_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = wdata_sh[8*i +: 8];
    end
  end

  // Single write port shared by the zero-fill and by committed stores;
  // the two never overlap because stores are only accepted in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_wdata = merged;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_idx   = clr_cnt_q;
        mem_wdata = 32'h0;
      end else if (store_commit) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  // Next-state and registered-output logic. Read data is captured from the
  // pre-write word at the accepting edge; a store in the previous cycle has
  // already landed by then, giving write-before-read ordering.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    rvalid_d   = 1'b0;
    rdata_d    = 32'h0;
    addr_err_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          addr_err_d = misalign;
          if (!WE) begin
            rvalid_d = 1'b1;
            rdata_d  = misalign ? 32'h0 : rdata_ext;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_CLEAR);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= CLEAR_ON_RESET;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign Ready   = ready_q;
  assign Busy    = busy_q;
  assign RValid  = rvalid_q;
  assign RData   = rdata_q;
  assign AddrErr = addr_err_q;

  // Simulation write trace: PC, word-aligned address, full merged word.
  if (TRACE) begin : g_trace
    always @(posedge Clk) begin
      if (store_commit) $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, merged);
    end
  end

endmodule

// File: tb/tb_dm_sized.sv
// tb_dm_sized: directed self-checking bench for dm_sized (default params).
// A table of accesses is issued back to back, one per cycle, and each
// response is compared right after its accepting edge; the reset/clear
// corner cases are hand-written sequences.
module tb_dm_sized;

  logic        Clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Req;
  logic        WE;
  logic [1:0]  Size;
  logic        Unsigned;
  logic        Ready;
  logic        Busy;
  logic        RValid;
  logic [31:0] RData;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;

  dm_sized dut (
    .Clk      (Clk),
    .reset    (reset),
    .PC       (PC),
    .Addr     (Addr),
    .WData    (WData),
    .Req      (Req),
    .WE       (WE),
    .Size     (Size),
    .Unsigned (Unsigned),
    .Ready    (Ready),
    .Busy     (Busy),
    .RValid   (RValid),
    .RData    (RData),
    .AddrErr  (AddrErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic exp_rv, input logic [31:0] exp_rd,
                              input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rv = exp_rv; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    PC       = 32'h0040_0000 + 32'(idx * 4);
    Req      = 1'b1;
    WE       = v.we;
    Size     = v.size;
    Unsigned = v.uns;
    Addr     = v.addr;
    WData    = v.wdata;
  endtask

  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    apply_stimulus(mk(we, size, uns, addr, wdata, 1'b0, 32'h0, 1'b0), 99);
    tick();
    Req = 1'b0;
  endtask

  // Counts the cycles Busy stays high, starting from a sample already taken
  // just after the reset edge; a runaway clear ends at the cycle bound.
  task automatic count_clear(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (Busy === 1'b1 && n < 5000) begin
      n++;
      if (Ready !== 1'b0) bad++;
      if (RValid !== 1'b0) bad++;
      tick();
    end
  endtask

  initial begin
    int n;
    int bad;

    reset = 1'b1; PC = 32'h0; Addr = 32'h0; WData = 32'h0;
    Req = 1'b0; WE = 1'b0; Size = 2'b10; Unsigned = 1'b0;

    // Reset values and the full zero-fill, with a load request held high
    // throughout to show nothing is accepted while clearing.
    tick();
    reset = 1'b0;
    check_output("reset_busy",   32'(Busy),    32'd1);
    check_output("reset_ready",  32'(Ready),   32'd0);
    check_output("reset_rvalid", 32'(RValid),  32'd0);
    check_output("reset_rdata",  RData,        32'h0);
    check_output("reset_err",    32'(AddrErr), 32'd0);
    Req = 1'b1; WE = 1'b0; Addr = 32'h0;
    count_clear(n, bad);
    Req = 1'b0;
    check_output("clear_cycles",      32'(n),     32'd1024);
    check_output("clear_ready_rv",    32'(bad),   32'd0);
    check_output("clear_done_ready",  32'(Ready), 32'd1);
    check_output("clear_done_busy",   32'(Busy),  32'd0);
    check_output("clear_no_rvalid",   32'(RValid),32'd0);

    // Directed access table: we, size, uns, addr, wdata, rvalid, rdata, err.
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_03FC, 32'h0,         1, 32'h0000_0000, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0000, 32'h0,         1, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0008, 32'h1234_5678, 0, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0009, 32'h0,         1, 32'h0000_0056, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0000_000B, 32'h0,         1, 32'h0000_0012, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_000A, 32'h0,         1, 32'h0000_1234, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0000_0008, 32'h0,         1, 32'h0000_5678, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0008, 32'h0,         1, 32'h0000_0078, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0020, 32'hF0E1_C2B3, 0, 32'h0,         0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0022, 32'h0,         1, 32'hFFFF_F0E1, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0000_0022, 32'h0,         1, 32'h0000_F0E1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0021, 32'h0,         1, 32'hFFFF_FFC2, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0000_0020, 32'h0,         1, 32'h0000_00B3, 0));
    vecs.push_back(mk(0, 2'b10, 1, 32'h0000_0020, 32'h0,         1, 32'hF0E1_C2B3, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_000C, 32'h0000_0000, 0, 32'h0,         0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h0000_000D, 32'h1234_5680, 0, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_000D, 32'h0,         1, 32'hFFFF_FF80, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0000_000D, 32'h0,         1, 32'h0000_0080, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_000C, 32'h0,         1, 32'h0000_8000, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0010, 32'hAAAA_AAAA, 0, 32'h0,         0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0013, 32'h0000_1111, 0, 32'h0,         1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0010, 32'h0,         1, 32'hAAAA_AAAA, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0012, 32'h0,         1, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0012, 32'h5555_BEEF, 0, 32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0010, 32'h0,         1, 32'hBEEF_AAAA, 0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h0000_0014, 32'h0,         1, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 2'b11, 0, 32'h0000_0014, 32'hFFFF_FFFF, 0, 32'h0,         1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0014, 32'h0,         1, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_1008, 32'hDEAD_BEEF, 0, 32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0008, 32'h0,         1, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 2'b10, 1, 32'hFFFF_F008, 32'h0,         1, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h0000_1003, 32'h0000_007F, 0, 32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0000, 32'h0,         1, 32'h7F00_0000, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0002, 32'h0,         1, 32'h0000_7F00, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0009, 32'h0,         1, 32'h0000_0000, 1));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i], i);
      tick();
      check_output($sformatf("vec%0d_rvalid", i), 32'(RValid),  32'(vecs[i].exp_rv));
      check_output($sformatf("vec%0d_rdata", i),  RData,        vecs[i].exp_rd);
      check_output($sformatf("vec%0d_err", i),    32'(AddrErr), 32'(vecs[i].exp_err));
    end
    Req = 1'b0;
    tick();
    check_output("idle_rvalid", 32'(RValid),  32'd0);
    check_output("idle_rdata",  RData,        32'h0);
    check_output("idle_err",    32'(AddrErr), 32'd0);
    check_output("idle_ready",  32'(Ready),   32'd1);

    // Reset mid-clear: mark the top word, reset, then reset again 500 cycles
    // into the clear with a load riding on the reset cycle.
    do_access(1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'h1111_1111);
    reset = 1'b1;
    Req = 1'b1; WE = 1'b0; Size = 2'b10; Addr = 32'h0000_0008;
    tick();
    reset = 1'b0; Req = 1'b0;
    check_output("rst1_rvalid", 32'(RValid), 32'd0);
    check_output("rst1_busy",   32'(Busy),   32'd1);
    for (int c = 0; c < 499; c++) tick();
    check_output("mid_busy",    32'(Busy),   32'd1);
    reset = 1'b1;
    Req = 1'b1; WE = 1'b1; Size = 2'b10; Addr = 32'h0000_0FFC; WData = 32'h2222_2222;
    tick();
    reset = 1'b0; Req = 1'b0;
    check_output("rst2_rvalid", 32'(RValid), 32'd0);
    check_output("rst2_ready",  32'(Ready),  32'd0);
    count_clear(n, bad);
    check_output("reclear_cycles", 32'(n),     32'd1024);
    check_output("reclear_bad",    32'(bad),   32'd0);
    check_output("reclear_ready",  32'(Ready), 32'd1);

    do_access(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0);
    check_output("top_cleared_rv", 32'(RValid), 32'd1);
    check_output("top_cleared_rd", RData,       32'h0);
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
    check_output("w8_cleared_rd",  RData,       32'h0);
    tick();
    check_output("final_rvalid",   32'(RValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
